// File: rtl/booths_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : booths_encoder
//  Description : Signed WIDTH x WIDTH multiplier that uses radix-8 Booth
//                recoding of B. The product is registered.
//                Define BOOTH_PIPE_EN to register the partial products as
//                well, which gives a latency of 2 instead of 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module booths_encoder #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   product
);

    localparam int C_PW = 2 * WIDTH;
    localparam int C_N  = (WIDTH + 3) / 3;
    localparam int C_BW = 3 * C_N;
    localparam logic [C_PW-1:0] C_ONE = {{(C_PW-1){1'b0}}, 1'b1};

    logic [C_BW:0]    w_bext;
    logic [C_PW-1:0]  w_a1;
    logic [C_PW-1:0]  w_a2;
    logic [C_PW-1:0]  w_a3;
    logic [C_PW-1:0]  w_a4;
    logic [WIDTH+1:0] w_a3_narrow;
    logic [C_PW-1:0]  w_pp [C_N];
    logic [C_PW-1:0]  w_sum;
    logic             w_sum_valid;
    logic [C_PW-1:0]  r_product;
    logic             r_out_valid;

    // Bit 0 is the implicit b[-1] = 0, so group i lives at w_bext[3i+3:3i].
    assign w_bext = {{(C_BW-WIDTH){B[WIDTH-1]}}, B, 1'b0};

    assign w_a1        = {{WIDTH{A[WIDTH-1]}}, A};
    assign w_a2        = w_a1 << 1;
    assign w_a4        = w_a1 << 2;
    assign w_a3_narrow = {{2{A[WIDTH-1]}}, A} + {A[WIDTH-1], A, 1'b0};
    assign w_a3        = {{(C_PW-WIDTH-2){w_a3_narrow[WIDTH+1]}}, w_a3_narrow};

    for (genvar gi = 0; gi < C_N; gi++) begin : g_pp
        logic [3:0]      w_grp;
        logic [C_PW-1:0] w_sel;
        logic [C_PW-1:0] w_signed;

        assign w_grp = w_bext[3*gi+3 -: 4];

        always_comb begin
            w_sel = '0;
            case (w_grp)
                4'b0001, 4'b0010, 4'b1101, 4'b1110: w_sel = w_a1;
                4'b0011, 4'b0100, 4'b1011, 4'b1100: w_sel = w_a2;
                4'b0101, 4'b0110, 4'b1001, 4'b1010: w_sel = w_a3;
                4'b0111, 4'b1000:                   w_sel = w_a4;
                default:                            w_sel = '0;
            endcase
        end

        // A negative digit with zero magnitude (1111) negates to zero as well.
        assign w_signed = w_grp[3] ? (~w_sel + C_ONE) : w_sel;
        assign w_pp[gi] = w_signed << (3 * gi);
    end

`ifdef BOOTH_PIPE_EN
    logic [C_PW-1:0] r_pp [C_N];
    logic            r_pp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < C_N; k++) begin
                r_pp[k] <= '0;
            end
            r_pp_valid <= 1'b0;
        end else begin
            for (int k = 0; k < C_N; k++) begin
                r_pp[k] <= w_pp[k];
            end
            r_pp_valid <= in_valid;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < C_N; k++) begin
            w_sum = w_sum + r_pp[k];
        end
    end

    assign w_sum_valid = r_pp_valid;
`else
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < C_N; k++) begin
            w_sum = w_sum + w_pp[k];
        end
    end

    assign w_sum_valid = in_valid;
`endif

    // The product holds its last value on cycles without a valid result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_sum_valid;
            if (w_sum_valid) begin
                r_product <= w_sum;
            end
        end
    end

    assign product   = r_product;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_booths_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booths_encoder
//  Description : Scoreboard bench for booths_encoder (either BOOTH_PIPE_EN build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booths_encoder;

    localparam int W     = 16;
    localparam int NRAND = 10000;
`ifdef BOOTH_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           out_valid;
    logic [2*W-1:0] product;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [2*W-1:0] exp_q [$];
    logic signed [2*W-1:0] last_prod;
    logic signed [2*W-1:0] e;
    logic signed [W-1:0]   va [8];
    logic signed [W-1:0]   vb [8];
    int                    vsr [LAT];
    logic                  exp_valid;

    booths_encoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .product   (product)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one cycle of stimulus and advances the scoreboard/valid model.
    task automatic tick(input logic v, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        @(negedge clk);
        in_valid = v;
        A        = a;
        B        = b;
        if (v) begin
            p = a * b;
            exp_q.push_back(p);
        end
        for (int k = LAT - 1; k > 0; k--) vsr[k] = vsr[k-1];
        vsr[0]    = v ? 1 : 0;
        exp_valid = (vsr[LAT-1] != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int k = 0; k < LAT; k++) vsr[k] = 0;
        exp_valid = 1'b0;
        last_prod = '0;
    endtask

    task automatic init_vectors();
        va[0] = -16'sd32767;  vb[0] = 16'sh8000;
        va[1] = 16'sd32767;   vb[1] = 16'sh8000;
        va[2] = 16'sh8000;    vb[2] = 16'sd32767;
        va[3] = 16'sd32767;   vb[3] = 16'sd32767;
        va[4] = 16'sh8000;    vb[4] = 16'sh8000;
        va[5] = 16'sd0;       vb[5] = -16'sd50;
        va[6] = -16'sd1003;   vb[6] = -16'sd5790;
        va[7] = -16'sd1;      vb[7] = 16'sd9930;
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        rst_n    = 1'b1;
        clear_model();
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (product !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: product=%0d out_valid=%b, want 0/0", product, out_valid);
        end
        in_valid = 1'b1;
        A        = 16'sd123;
        B        = 16'sd45;
        repeat (3) @(negedge clk);
        n_tests++;
        if (product !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: product=%0d out_valid=%b, want 0/0", product, out_valid);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, '0);
            n_tests++;
            if (out_valid !== 1'b0 || product !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: product=%0d out_valid=%b, want 0/0", i, product, out_valid);
            end
        end
    endtask

    // Each vector issued alone with idle cycles between.
    task automatic test_corners();
        for (int i = 0; i < 16 + LAT + 1; i++) begin
            if (i < 16 && i % 2 == 0) tick(1'b1, va[i/2], vb[i/2]);
            else                      tick(1'b0, 16'sd7, 16'sd9);
            n_tests++;
            if (out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL corners_valid cyc %0d: got %b want %b", i, out_valid, exp_valid);
            end
            n_tests++;
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL corners_queue cyc %0d: got out_valid with empty scoreboard want entry", i);
                end else begin
                    e = exp_q.pop_front();
                    last_prod = e;
                    if (product !== e) begin
                        n_fail++;
                        $display("FAIL corners_product cyc %0d: got %0d want %0d", i, $signed(product), e);
                    end
                end
            end else if (product !== last_prod) begin
                n_fail++;
                $display("FAIL corners_hold cyc %0d: got %0d want %0d", i, $signed(product), last_prod);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nv = 0;
        for (int i = 0; i < 8 + LAT + 1; i++) begin
            if (i < 8) tick(1'b1, va[i], vb[i]);
            else       tick(1'b0, '0, '0);
            if (out_valid === 1'b1) nv++;
            n_tests++;
            if (out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL b2b_valid cyc %0d: got %b want %b", i, out_valid, exp_valid);
            end
            n_tests++;
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_queue cyc %0d: got out_valid with empty scoreboard want entry", i);
                end else begin
                    e = exp_q.pop_front();
                    last_prod = e;
                    if (product !== e) begin
                        n_fail++;
                        $display("FAIL b2b_product cyc %0d: got %0d want %0d", i, $signed(product), e);
                    end
                end
            end else if (product !== last_prod) begin
                n_fail++;
                $display("FAIL b2b_hold cyc %0d: got %0d want %0d", i, $signed(product), last_prod);
            end
        end
        n_tests++;
        if (nv != 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d valid cycles want 8", nv);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, va[i+5], vb[i+5]);
            n_tests++;
            if (out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL mid_valid cyc %0d: got %b want %b", i, out_valid, exp_valid);
            end
            if (exp_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                last_prod = e;
                n_tests++;
                if (product !== e) begin
                    n_fail++;
                    $display("FAIL mid_product cyc %0d: got %0d want %0d", i, $signed(product), e);
                end
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        n_tests++;
        if (product !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: product=%0d out_valid=%b, want 0/0", product, out_valid);
        end
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, va[i], vb[i]);
            n_tests++;
            if (out_valid !== 1'b0 || product !== '0) begin
                n_fail++;
                $display("FAIL mid_after_release cyc %0d: product=%0d out_valid=%b, want 0/0", i, product, out_valid);
            end
        end
    endtask

    task automatic test_random();
        int issued = 0;
        int drain  = 0;
        int cyc    = 0;
        logic                v;
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        while (drain <= LAT && cyc < 30000) begin
            v = (issued < NRAND) && ($urandom_range(3) != 0);
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(15) == 0) a = va[$urandom_range(7)];
            if ($urandom_range(15) == 0) b = vb[$urandom_range(7)];
            if (v) issued++;
            if (issued >= NRAND && !v) drain++;
            tick(v, a, b);
            cyc++;
            n_tests++;
            if (out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, out_valid, exp_valid);
            end
            n_tests++;
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_queue cyc %0d: got out_valid with empty scoreboard want entry", cyc);
                end else begin
                    e = exp_q.pop_front();
                    last_prod = e;
                    if (product !== e) begin
                        n_fail++;
                        $display("FAIL rand_product cyc %0d: got %0d want %0d", cyc, $signed(product), e);
                    end
                end
            end else if (product !== last_prod) begin
                n_fail++;
                $display("FAIL rand_hold cyc %0d: got %0d want %0d", cyc, $signed(product), last_prod);
            end
        end
        n_tests++;
        if (exp_q.size() != 0 || issued != NRAND) begin
            n_fail++;
            $display("FAIL rand_drain: got %0d pending, %0d issued want 0 pending, %0d issued",
                     exp_q.size(), issued, NRAND);
        end
    endtask

    initial begin
        init_vectors();
        test_reset();
        test_corners();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
